// File: rtl/score_bin2bcd_seq.sv
// score_bin2bcd_seq
//   Multi-cycle double-dabble converter from the binary score to four BCD
//   digits. The result digits are held stable between conversions, so the
//   digit renderer never sees intermediate shift values.
//
//   Ports:
//     clk, reset        clock; asynchronous active-high reset
//     start, in         conversion request; in is sampled on the accepting edge
//     ready             idle and able to accept start (combinational)
//     busy              conversion in progress (registered)
//     done              one-cycle pulse; new digits valid in the same cycle
//     bcd3..bcd0        result digits, bcd3 = thousands
//     overflow          accepted input exceeded MAX_VALUE and was clamped
//
//   Build option:
//     SCORE_BCD_PENDING_START_EN - a start seen while busy is held in a
//     one-deep pending slot (newest wins) and launched straight from DONE.
module score_bin2bcd_seq #(
   parameter int BIN_WIDTH = 14,
   parameter int DIGITS    = 4,
   parameter int MAX_VALUE = 9999
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [BIN_WIDTH-1:0] in,
   output logic                 ready,
   output logic                 busy,
   output logic                 done,
   output logic [3:0]           bcd3,
   output logic [3:0]           bcd2,
   output logic [3:0]           bcd1,
   output logic [3:0]           bcd0,
   output logic                 overflow
);

   localparam int BCD_W = DIGITS * 4;
   localparam int SR_W  = BCD_W + BIN_WIDTH;
   localparam int CNT_W = $clog2(BIN_WIDTH + 1);

   localparam logic [BIN_WIDTH-1:0] MAX_V    = BIN_WIDTH'(MAX_VALUE);
   localparam logic [CNT_W-1:0]     CNT_LOAD = CNT_W'(BIN_WIDTH);
   localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CONV = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]           state_q, state_d;
   logic [SR_W-1:0]      sr_q, sr_d, sr_adj;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 ovf_q, ovf_d;
   logic [BCD_W-1:0]     bcd_q, bcd_d;

   logic                 in_ovf;
   logic [BIN_WIDTH-1:0] in_val;
   logic                 load;
   logic [BIN_WIDTH-1:0] load_val;
   logic                 load_ovf;

`ifdef SCORE_BCD_PENDING_START_EN
   logic                 pend_q, pend_d;
   logic [BIN_WIDTH-1:0] pend_val_q, pend_val_d;
   logic                 pend_ovf_q, pend_ovf_d;
`endif

   assign in_ovf = (in > MAX_V);
   assign in_val = in_ovf ? MAX_V : in;

   // Double-dabble adjust: each BCD field >= 5 gets +3 independently.
   always_comb begin
      sr_adj = sr_q;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (sr_q[BIN_WIDTH + 4*i +: 4] >= 4'd5)
            sr_adj[BIN_WIDTH + 4*i +: 4] = sr_q[BIN_WIDTH + 4*i +: 4] + 4'd3;
      end
   end

   always_comb begin
      state_d  = state_q;
      sr_d     = sr_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      ovf_d    = ovf_q;
      bcd_d    = bcd_q;
      load     = 1'b0;
      load_val = in_val;
      load_ovf = in_ovf;
`ifdef SCORE_BCD_PENDING_START_EN
      pend_d     = pend_q;
      pend_val_d = pend_val_q;
      pend_ovf_d = pend_ovf_q;
`endif

      case (state_q)
         ST_IDLE: begin
            load = start;
         end
         ST_CONV: begin
            sr_d  = {sr_adj[SR_W-2:0], 1'b0};
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE)
               state_d = ST_DONE;
`ifdef SCORE_BCD_PENDING_START_EN
            if (start) begin
               pend_d     = 1'b1;
               pend_val_d = in_val;
               pend_ovf_d = in_ovf;
            end
`endif
         end
         ST_DONE: begin
            bcd_d   = sr_q[SR_W-1 -: BCD_W];
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
`ifdef SCORE_BCD_PENDING_START_EN
            // A start on this very edge is newer than anything pending.
            load     = start | pend_q;
            load_val = start ? in_val : pend_val_q;
            load_ovf = start ? in_ovf : pend_ovf_q;
            pend_d   = 1'b0;
`endif
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase

      if (load) begin
         sr_d    = {{BCD_W{1'b0}}, load_val};
         cnt_d   = CNT_LOAD;
         state_d = ST_CONV;
         busy_d  = 1'b1;
         ovf_d   = load_ovf;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         sr_q    <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
         bcd_q   <= '0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         ovf_q   <= ovf_d;
         bcd_q   <= bcd_d;
      end
   end

`ifdef SCORE_BCD_PENDING_START_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_q     <= 1'b0;
         pend_val_q <= '0;
         pend_ovf_q <= 1'b0;
      end else begin
         pend_q     <= pend_d;
         pend_val_q <= pend_val_d;
         pend_ovf_q <= pend_ovf_d;
      end
   end
`endif

   assign ready    = (state_q == ST_IDLE);
   assign busy     = busy_q;
   assign done     = done_q;
   assign overflow = ovf_q;
   assign bcd3     = bcd_q[15:12];
   assign bcd2     = bcd_q[11:8];
   assign bcd1     = bcd_q[7:4];
   assign bcd0     = bcd_q[3:0];

endmodule

// File: tb/tb_score_bin2bcd_seq.sv
// Testbench for score_bin2bcd_seq: transaction-level reference model plus
// directed scenarios and randomized start/in traffic.
module tb_score_bin2bcd_seq;

   localparam int BW   = 14;
   localparam int MAXV = 9999;
   localparam int LAT  = BW + 1;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic [BW-1:0] in_bin = '0;
   logic          ready, busy, done, overflow;
   logic [3:0]    bcd3, bcd2, bcd1, bcd0;

   int n_assert = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   score_bin2bcd_seq #(.BIN_WIDTH(BW), .DIGITS(4), .MAX_VALUE(MAXV)) dut (
      .clk(clk), .reset(reset), .start(start), .in(in_bin),
      .ready(ready), .busy(busy), .done(done),
      .bcd3(bcd3), .bcd2(bcd2), .bcd1(bcd1), .bcd0(bcd0),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] to_bcd(input int v);
      return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   function automatic int clampv(input int v);
      return (v > MAXV) ? MAXV : v;
   endfunction

   // Reference model: a conversion takes LAT edges from acceptance to done.
   int          m_rem  = 0;
   int          m_cur  = 0;
   bit          m_done = 1'b0;
   bit          m_ovf  = 1'b0;
   logic [15:0] m_bcd  = '0;
`ifdef SCORE_BCD_PENDING_START_EN
   bit          m_pend   = 1'b0;
   int          m_pend_v = 0;
   bit          m_pend_o = 1'b0;
`endif

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_rem  = 0;
         m_done = 1'b0;
         m_ovf  = 1'b0;
         m_bcd  = '0;
`ifdef SCORE_BCD_PENDING_START_EN
         m_pend = 1'b0;
`endif
      end else begin
         m_done = 1'b0;
         if (m_rem != 0) begin
`ifdef SCORE_BCD_PENDING_START_EN
            if (start) begin
               m_pend   = 1'b1;
               m_pend_v = clampv(int'(in_bin));
               m_pend_o = (int'(in_bin) > MAXV);
            end
`endif
            m_rem--;
            if (m_rem == 0) begin
               m_done = 1'b1;
               m_bcd  = to_bcd(m_cur);
`ifdef SCORE_BCD_PENDING_START_EN
               if (m_pend) begin
                  m_cur  = m_pend_v;
                  m_ovf  = m_pend_o;
                  m_rem  = LAT;
                  m_pend = 1'b0;
               end
`endif
            end
         end else if (start) begin
            m_cur = clampv(int'(in_bin));
            m_ovf = (int'(in_bin) > MAXV);
            m_rem = LAT;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("ready",    int'(ready),    int'(m_rem == 0));
         check("busy",     int'(busy),     int'(m_rem != 0));
         check("done",     int'(done),     int'(m_done));
         check("overflow", int'(overflow), int'(m_ovf));
         check("bcd",      int'({bcd3, bcd2, bcd1, bcd0}), int'(m_bcd));
      end
   end

   task automatic do_start(input int v);
      start  = 1'b1;
      in_bin = BW'(v);
      @(posedge clk);
      #2;
      start  = 1'b0;
   endtask

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #2;
      end
   endtask

   // Returns the number of negedges passed before done was seen (bounded).
   task automatic wait_done(output int n);
      n = 0;
      while (n < 40) begin
         @(negedge clk);
         if (done) break;
         n++;
      end
      if (n >= 40) begin
         n_assert++;
         n_fail++;
         $display("FAIL wait_done: got timeout expected done within 40 cycles");
      end
   endtask

   task automatic drain();
      int k = 0;
      while (busy && k < 60) begin
         @(negedge clk);
         k++;
      end
      check("drain_idle", int'(busy), 0);
   endtask

   int n;
   int cnt;

   initial begin
      #1 reset = 1'b1;
      #1 chk_en = 1'b1;
      check("rst_bcd",   int'({bcd3, bcd2, bcd1, bcd0}), 0);
      check("rst_busy",  int'(busy), 0);
      check("rst_ready", int'(ready), 1);
      cyc(2);
      reset = 1'b0;
      cyc(1);

      // in=0: done after 15 edges
      do_start(0);
      wait_done(n);
      check("lat_0", n, 15);
      check("bcd_0", int'({bcd3, bcd2, bcd1, bcd0}), 'h0000);
      check("ovf_0", int'(overflow), 0);

      do_start(9990);
      wait_done(n);
      check("bcd_9990", int'({bcd3, bcd2, bcd1, bcd0}), 'h9990);
      do_start(10);
      wait_done(n);
      check("bcd_10", int'({bcd3, bcd2, bcd1, bcd0}), 'h0010);
      cyc(20);
      check("hold_10", int'({bcd3, bcd2, bcd1, bcd0}), 'h0010);

      do_start(12345);
      wait_done(n);
      check("bcd_clamp", int'({bcd3, bcd2, bcd1, bcd0}), 'h9999);
      check("ovf_clamp", int'(overflow), 1);
      do_start(42);
      wait_done(n);
      check("bcd_42", int'({bcd3, bcd2, bcd1, bcd0}), 'h0042);
      check("ovf_42",  int'(overflow), 0);

      // second start at edge 5 of a running conversion
      do_start(1234);
      cyc(4);
      do_start(5678);
      wait_done(n);
      check("lat_1234", n, 10);
      check("bcd_1234", int'({bcd3, bcd2, bcd1, bcd0}), 'h1234);
`ifdef SCORE_BCD_PENDING_START_EN
      wait_done(n);
      check("lat_5678", n, 14);
      check("bcd_5678", int'({bcd3, bcd2, bcd1, bcd0}), 'h5678);
`else
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done) cnt++;
      end
      check("no_2nd_done", cnt, 0);
      check("bcd_1234_hold", int'({bcd3, bcd2, bcd1, bcd0}), 'h1234);
`endif

      // reset in the middle of a conversion
      cyc(1);
      do_start(8888);
      cyc(6);
      #1 reset = 1'b1;
      #1;
      check("midrst_bcd",  int'({bcd3, bcd2, bcd1, bcd0}), 0);
      check("midrst_busy", int'(busy), 0);
      check("midrst_done", int'(done), 0);
      cyc(1);
      reset = 1'b0;
      do_start(8888);
      wait_done(n);
      check("lat_8888", n, 15);
      check("bcd_8888", int'({bcd3, bcd2, bcd1, bcd0}), 'h8888);

      // start held high continuously
      #1;
      start  = 1'b1;
      in_bin = BW'(20);
      cnt = 0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (done) cnt++;
      end
      start = 1'b0;
      check("held_done_cnt", cnt, 4);
      check("bcd_20", int'({bcd3, bcd2, bcd1, bcd0}), 'h0020);
      drain();

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         #1;
         start = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 3) == 0)
            in_bin = BW'($urandom_range(MAXV - 20, (1 << BW) - 1));
         else
            in_bin = BW'($urandom_range(0, MAXV));
      end
      start = 1'b0;
      drain();
      cyc(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/score_bin2bcd_seq.md
Name: score_bin2bcd_seq

Overview:
- Multi-cycle double-dabble converter between the score register and the score digit renderer.
- Converts the binary score on each start pulse into four BCD digits.
- Holds the last result stable on its outputs, so the renderer never sees intermediate shift values during a VGA frame.
- Start/done handshake; one conversion in flight.

Parameters:
- BIN_WIDTH, 14: width of binary input.
- DIGITS, 4: BCD digits produced. Outputs bcd3..bcd0 are fixed at 4 digits; DIGITS must be 4.
- MAX_VALUE, 9999: saturation limit; equals 10^DIGITS-1.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request conversion of in; sampled on posedge clk.
- in  in  BIN_WIDTH  binary value, sampled on the accepting edge only.
- ready  out  1  high when idle and able to accept start (combinational from state).
- busy  out  1  registered; high while a conversion is in progress.
- done  out  1  registered one-cycle pulse; new digits valid in the same cycle.
- bcd3, bcd2, bcd1, bcd0  out  4 each  registered result digits; bcd3 is the thousands digit.
- overflow  out  1  registered; set when the accepted in exceeded MAX_VALUE.

Behaviour:
- Reset (async): state=IDLE; bcd3..bcd0=0; done=0; busy=0; overflow=0; shift register and counter cleared.
- FSM states are IDLE, CONV, DONE.
- IDLE to CONV, on an edge with start=1:
  - Load value: in, or MAX_VALUE if in>MAX_VALUE.
  - Load shift register {DIGITS*4 zeros, value}, width DIGITS*4+BIN_WIDTH.
  - Load counter = BIN_WIDTH.
  - busy=1; overflow is updated at this edge (1 if clamped, else 0).
- CONV, each edge:
  - For each 4-bit digit field, if it is >=5, add 3 (no carry between fields).
  - Then shift the whole register left by 1 and decrement the counter.
  - When the counter reaches 0 after this edge, go to DONE.
  - Exactly BIN_WIDTH iterations are performed.
- DONE to IDLE, on the next edge:
  - Copy the upper DIGITS*4 bits to bcd3..bcd0.
  - done=1 for exactly one cycle; busy=0.
- Latency: start sampled at edge 0; digits updated and done high after edge BIN_WIDTH+1 (15 cycles at defaults).
- Back-to-back: start may be asserted in the cycle done is high, since ready=1 then; that next conversion starts normally.
- bcd outputs change only at the DONE to IDLE edge and hold indefinitely otherwise.
- Start while not IDLE: ignored, unless the optional feature is enabled.
- Reset mid-conversion: immediate return to the reset state; the partial result is discarded; no done pulse.
- Counter width is clog2(BIN_WIDTH+1). Adjust and add arithmetic stays within 4 bits per digit. A digit never exceeds 9 at the output.

Optional Feature:
- Macro: SCORE_BCD_PENDING_START_EN.
- Defined:
  - A start seen while busy latches the clamped in value into a one-deep pending register and sets a pending flag.
  - A later start while still busy overwrites the pending value (newest wins).
  - At the DONE to IDLE edge with pending set, the FSM goes directly to CONV using the pending value; done still pulses for the finished conversion.
  - ready stays low in this case; reset clears pending.
- Not defined: a start while busy is dropped; no pending storage is synthesized.

Test Plan:
- Reset, then start with in=0 -> after 15 cycles done pulses once; bcd=0,0,0,0; overflow=0; busy high for exactly 15 cycles.
- start with in=9990 -> done at cycle 15; bcd3..bcd0=9,9,9,0. Then start with in=10 -> 0,0,1,0. Outputs hold between conversions.
- start with in=12345 -> bcd=9,9,9,9 and overflow=1. A following conversion of in=42 -> 0,0,4,2 and overflow=0.
- start with in=1234, then start with in=5678 at cycle 5:
  - Macro off: single done; result 1,2,3,4.
  - Macro on: done at cycle 15 with 1,2,3,4; second done at cycle 30 with 5,6,7,8.
- Assert reset at cycle 7 of a conversion of in=8888 -> all outputs 0 immediately; no done pulse; next start with in=8888 yields 8,8,8,8.
- start held high continuously with in=20 -> a conversion restarts every 16 cycles; done pulses each time; digits stay 0,0,2,0.
